// File: rtl/mem_port_arbiter.sv
// Round-robin fetch/load-store arbiter onto one word memory port; sub-word stores do read-modify-write.
// Response 2 cycles after grant (3 for byte/half stores); requests stall via ready outside IDLE, responses never stall.
module mem_port_arbiter (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        in_fetch_req_valid,
    output logic        out_fetch_req_ready,
    input  logic [31:0] in_fetch_addr,
    output logic        out_fetch_resp_valid,
    output logic [31:0] out_fetch_resp_data,
    output logic        out_fetch_resp_exception,
    input  logic        in_data_req_valid,
    output logic        out_data_req_ready,
    input  logic        in_data_req_write,
    input  logic [1:0]  in_data_req_size,
    input  logic [31:0] in_data_req_addr,
    input  logic [31:0] in_data_req_wdata,
    output logic        out_data_resp_valid,
    output logic [31:0] out_data_resp_data,
    output logic        out_data_resp_exception,
    output logic [31:0] out_mem_read_address,
    input  logic [31:0] in_mem_read_data,
    output logic        out_mem_write_enable,
    output logic [31:0] out_mem_write_address,
    output logic [31:0] out_mem_write_data
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WRITE = 2'd2} state_t;

    state_t      state_q, state_d;
    logic        prio_data_q, prio_data_d;
    logic        src_data_q, src_data_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic        f_vld_q, f_vld_d, f_exc_q, f_exc_d;
    logic [31:0] f_dat_q, f_dat_d;
    logic        d_vld_q, d_vld_d, d_exc_q, d_exc_d;
    logic [31:0] d_dat_q, d_dat_d;

    logic        grant_f, grant_d, we_c, misaligned;
    logic        resp_fire, resp_exc;
    logic [31:0] resp_data;
    logic [31:0] word_addr, load_shifted, load_data, lane_mask, wdata_shifted, merged;
    logic [3:0]  byte_en;

    assign word_addr  = {addr_q[31:2], 2'b00};
    assign misaligned = (size_q == 2'd3)
                     || (size_q == 2'd1 && addr_q[0])
                     || (size_q == 2'd2 && addr_q[1:0] != 2'b00);

    assign load_shifted = in_mem_read_data >> {addr_q[1:0], 3'b000};
    always_comb begin
        case (size_q)
            2'd0:    load_data = {24'd0, load_shifted[7:0]};
            2'd1:    load_data = {16'd0, load_shifted[15:0]};
            default: load_data = load_shifted;
        endcase
    end

    // Sub-word store merge: only the addressed lanes take the new data.
    assign byte_en       = (size_q == 2'd0 ? 4'b0001 : 4'b0011) << addr_q[1:0];
    assign lane_mask     = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};
    assign wdata_shifted = wdata_q << {addr_q[1:0], 3'b000};
    assign merged        = (word_q & ~lane_mask) | (wdata_shifted & lane_mask);

    // Each side's ready drops when the other side holds priority and is requesting,
    // so at most one handshake can happen per cycle.
    assign out_fetch_req_ready = (state_q == IDLE) && !RESET && !(in_data_req_valid && prio_data_q);
    assign out_data_req_ready  = (state_q == IDLE) && !RESET && !(in_fetch_req_valid && !prio_data_q);
    assign grant_f = out_fetch_req_ready && in_fetch_req_valid;
    assign grant_d = out_data_req_ready && in_data_req_valid;

    always_comb begin
        state_d     = state_q;
        prio_data_d = prio_data_q;
        src_data_d  = src_data_q;
        addr_d      = addr_q;
        size_d      = size_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        word_d      = word_q;
        resp_fire   = 1'b0;
        resp_exc    = 1'b0;
        resp_data   = 32'd0;
        we_c        = 1'b0;
        out_mem_read_address  = 32'd0;
        out_mem_write_address = 32'd0;
        out_mem_write_data    = 32'd0;
        case (state_q)
            IDLE: begin
                if (grant_f || grant_d) begin
                    src_data_d  = grant_d;
                    addr_d      = grant_d ? in_data_req_addr : in_fetch_addr;
                    size_d      = grant_d ? in_data_req_size : 2'd2;
                    write_d     = grant_d && in_data_req_write;
                    wdata_d     = grant_d ? in_data_req_wdata : 32'd0;
                    prio_data_d = grant_f;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                out_mem_read_address = word_addr;
                state_d   = IDLE;
                resp_fire = 1'b1;
                if (misaligned) begin
                    resp_exc = 1'b1;
                end else if (!write_q) begin
                    resp_data = src_data_q ? load_data : in_mem_read_data;
                end else if (size_q == 2'd2) begin
                    we_c                  = 1'b1;
                    out_mem_write_address = word_addr;
                    out_mem_write_data    = wdata_q;
                end else begin
                    word_d    = in_mem_read_data;
                    resp_fire = 1'b0;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                we_c                  = 1'b1;
                out_mem_write_address = word_addr;
                out_mem_write_data    = merged;
                resp_fire             = 1'b1;
                state_d               = IDLE;
            end
            default: state_d = IDLE;
        endcase
        f_vld_d = resp_fire && !src_data_q;
        f_dat_d = f_vld_d ? resp_data : 32'd0;
        f_exc_d = f_vld_d && resp_exc;
        d_vld_d = resp_fire && src_data_q;
        d_dat_d = d_vld_d ? resp_data : 32'd0;
        d_exc_d = d_vld_d && resp_exc;
    end

    assign out_mem_write_enable = we_c && !RESET;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            prio_data_q <= 1'b0;
            src_data_q  <= 1'b0;
            addr_q      <= 32'd0;
            size_q      <= 2'd0;
            write_q     <= 1'b0;
            wdata_q     <= 32'd0;
            word_q      <= 32'd0;
            f_vld_q     <= 1'b0;
            f_dat_q     <= 32'd0;
            f_exc_q     <= 1'b0;
            d_vld_q     <= 1'b0;
            d_dat_q     <= 32'd0;
            d_exc_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_data_q <= prio_data_d;
            src_data_q  <= src_data_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            word_q      <= word_d;
            f_vld_q     <= f_vld_d;
            f_dat_q     <= f_dat_d;
            f_exc_q     <= f_exc_d;
            d_vld_q     <= d_vld_d;
            d_dat_q     <= d_dat_d;
            d_exc_q     <= d_exc_d;
        end
    end

    assign out_fetch_resp_valid     = f_vld_q;
    assign out_fetch_resp_data      = f_dat_q;
    assign out_fetch_resp_exception = f_exc_q;
    assign out_data_resp_valid      = d_vld_q;
    assign out_data_resp_data       = d_dat_q;
    assign out_data_resp_exception  = d_exc_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cases, round-robin, reset abort, and random traffic vs a byte-level model.
module tb_mem_port_arbiter;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        in_fetch_req_valid, out_fetch_req_ready;
    logic [31:0] in_fetch_addr;
    logic        out_fetch_resp_valid, out_fetch_resp_exception;
    logic [31:0] out_fetch_resp_data;
    logic        in_data_req_valid, out_data_req_ready, in_data_req_write;
    logic [1:0]  in_data_req_size;
    logic [31:0] in_data_req_addr, in_data_req_wdata;
    logic        out_data_resp_valid, out_data_resp_exception;
    logic [31:0] out_data_resp_data;
    logic [31:0] out_mem_read_address, in_mem_read_data;
    logic        out_mem_write_enable;
    logic [31:0] out_mem_write_address, out_mem_write_data;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    logic        mem_init, poke_en;
    logic [31:0] poke_addr, poke_data;
    int errors = 0;
    int checks = 0;

    mem_port_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .in_fetch_req_valid(in_fetch_req_valid), .out_fetch_req_ready(out_fetch_req_ready),
        .in_fetch_addr(in_fetch_addr),
        .out_fetch_resp_valid(out_fetch_resp_valid), .out_fetch_resp_data(out_fetch_resp_data),
        .out_fetch_resp_exception(out_fetch_resp_exception),
        .in_data_req_valid(in_data_req_valid), .out_data_req_ready(out_data_req_ready),
        .in_data_req_write(in_data_req_write), .in_data_req_size(in_data_req_size),
        .in_data_req_addr(in_data_req_addr), .in_data_req_wdata(in_data_req_wdata),
        .out_data_resp_valid(out_data_resp_valid), .out_data_resp_data(out_data_resp_data),
        .out_data_resp_exception(out_data_resp_exception),
        .out_mem_read_address(out_mem_read_address), .in_mem_read_data(in_mem_read_data),
        .out_mem_write_enable(out_mem_write_enable), .out_mem_write_address(out_mem_write_address),
        .out_mem_write_data(out_mem_write_data)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] pattern(input int i);
        return (32'(i) * 32'h01030507) ^ 32'h5A5A0000;
    endfunction

    // Memory attached to the DUT port
    assign in_mem_read_data = mem[out_mem_read_address[9:2]];
    always @(posedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= pattern(i);
        end else if (poke_en) begin
            mem[poke_addr[9:2]] <= poke_data;
        end else if (out_mem_write_enable) begin
            mem[out_mem_write_address[9:2]] <= out_mem_write_data;
        end
    end

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input int off, input int nb);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < nb; i++) r[8*i +: 8] = w[8*(off+i) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input int off, input int nb,
                                                input logic [31:0] wd);
        logic [31:0] r;
        r = w;
        for (int i = 0; i < nb; i++) r[8*(off+i) +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        @(negedge CLK);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge CLK); #1;
        poke_en = 1'b0;
        ref_mem[a[9:2]] = d;
    endtask

    task automatic do_req(input bit is_data, input bit wr, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] wd, input string tag);
        int nb, off, rsp_k, wr_k, waited;
        bit mis;
        logic [31:0] w, exp_data, exp_wdat, exp_raddr, got_d;
        logic got_e;
        if (!is_data) begin wr = 1'b0; sz = 2'd2; end
        nb  = nbytes(sz);
        off = int'(addr[1:0]);
        mis = (sz == 2'd3) || (off % nb != 0);
        w   = ref_mem[addr[9:2]];
        exp_data = 32'd0; exp_wdat = 32'd0; rsp_k = 2; wr_k = 0;
        if (!mis) begin
            if (!wr) begin
                exp_data = model_load(w, off, nb);
            end else begin
                exp_wdat = model_store(w, off, nb, wd);
                ref_mem[addr[9:2]] = exp_wdat;
                wr_k  = (nb == 4) ? 1 : 2;
                rsp_k = wr_k + 1;
            end
        end
        @(negedge CLK);
        if (is_data) begin
            in_data_req_valid = 1'b1; in_data_req_write = wr; in_data_req_size = sz;
            in_data_req_addr = addr; in_data_req_wdata = wd;
        end else begin
            in_fetch_req_valid = 1'b1; in_fetch_addr = addr;
        end
        #1;
        waited = 0;
        while (!(is_data ? out_data_req_ready : out_fetch_req_ready) && waited < 10) begin
            @(negedge CLK); #1; waited++;
        end
        checks++;
        if (waited >= 10) begin
            errors++;
            $display("FAIL %s grant: ready stayed 0, required 1", tag);
            in_fetch_req_valid = 1'b0; in_data_req_valid = 1'b0;
            return;
        end
        @(posedge CLK); #1;
        in_fetch_req_valid = 1'b0; in_data_req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            exp_raddr = (k == 1) ? {addr[31:2], 2'b00} : 32'd0;
            checks++;
            if (out_mem_read_address !== exp_raddr) begin
                errors++;
                $display("FAIL %s read_addr c%0d: got %h, required %h", tag, k, out_mem_read_address, exp_raddr);
            end
            checks++;
            if (out_mem_write_enable !== (k == wr_k)) begin
                errors++;
                $display("FAIL %s write_en c%0d: got %b, required %b", tag, k, out_mem_write_enable, k == wr_k);
            end
            if (k == wr_k) begin
                checks++;
                if (out_mem_write_address !== {addr[31:2], 2'b00} || out_mem_write_data !== exp_wdat) begin
                    errors++;
                    $display("FAIL %s write c%0d: got %h@%h, required %h@%h", tag, k, out_mem_write_data,
                             out_mem_write_address, exp_wdat, {addr[31:2], 2'b00});
                end
            end
            checks++;
            if (out_fetch_resp_valid !== (!is_data && k == rsp_k) || out_data_resp_valid !== (is_data && k == rsp_k)) begin
                errors++;
                $display("FAIL %s resp_valid c%0d: got f=%b d=%b, required f=%b d=%b", tag, k,
                         out_fetch_resp_valid, out_data_resp_valid, !is_data && k == rsp_k, is_data && k == rsp_k);
            end
            if (k == rsp_k) begin
                got_d = is_data ? out_data_resp_data : out_fetch_resp_data;
                got_e = is_data ? out_data_resp_exception : out_fetch_resp_exception;
                checks++;
                if (got_d !== exp_data || got_e !== mis) begin
                    errors++;
                    $display("FAIL %s resp: got data=%h exc=%b, required data=%h exc=%b", tag, got_d, got_e, exp_data, mis);
                end
                checks++;
                if (out_fetch_req_ready !== 1'b1 || out_data_req_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s ready_at_resp: got f=%b d=%b, required 1 1", tag,
                             out_fetch_req_ready, out_data_req_ready);
                end
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; mem_init = 1'b1; poke_en = 1'b0; poke_addr = 32'd0; poke_data = 32'd0;
        in_fetch_req_valid = 1'b0; in_fetch_addr = 32'd0;
        in_data_req_valid = 1'b0; in_data_req_write = 1'b0; in_data_req_size = 2'd0;
        in_data_req_addr = 32'd0; in_data_req_wdata = 32'd0;
        for (int i = 0; i < 256; i++) ref_mem[i] = pattern(i);
        repeat (3) @(posedge CLK);
        #1;
        mem_init = 1'b0;
        checks++;
        if (out_mem_write_enable !== 1'b0) begin
            errors++; $display("FAIL reset_we: got %b, required 0", out_mem_write_enable);
        end
        RESET = 1'b0; #1;
        checks++;
        if (out_fetch_req_ready !== 1'b1 || out_data_req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got f=%b d=%b, required 1 1", out_fetch_req_ready, out_data_req_ready);
        end
        checks++;
        if (out_fetch_resp_valid !== 1'b0 || out_fetch_resp_data !== 32'd0 || out_fetch_resp_exception !== 1'b0) begin
            errors++; $display("FAIL reset_fetch_resp: got v=%b d=%h e=%b, required 0", out_fetch_resp_valid,
                               out_fetch_resp_data, out_fetch_resp_exception);
        end
        checks++;
        if (out_data_resp_valid !== 1'b0 || out_data_resp_data !== 32'd0 || out_data_resp_exception !== 1'b0) begin
            errors++; $display("FAIL reset_data_resp: got v=%b d=%h e=%b, required 0", out_data_resp_valid,
                               out_data_resp_data, out_data_resp_exception);
        end
        checks++;
        if (out_mem_read_address !== 32'd0) begin
            errors++; $display("FAIL reset_raddr: got %h, required 0", out_mem_read_address);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1; in_fetch_req_valid = 1'b0; in_data_req_valid = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        RESET = 1'b0;
    endtask

    task automatic test_directed();
        poke(32'h100, 32'h00C0FFEE);
        do_req(1'b0, 1'b0, 2'd2, 32'h100, 32'd0, "fetch_100");
        poke(32'h100, 32'hAABBCCDD);
        do_req(1'b1, 1'b0, 2'd0, 32'h103, 32'd0, "load_byte_103");
        poke(32'h200, 32'h55667788);
        do_req(1'b1, 1'b1, 2'd1, 32'h202, 32'h1234, "store_half_202");
        do_req(1'b1, 1'b0, 2'd2, 32'h301, 32'd0, "load_word_301");
        do_req(1'b1, 1'b1, 2'd3, 32'h300, 32'hFFFFFFFF, "size3_store");
        do_req(1'b0, 1'b0, 2'd2, 32'h102, 32'd0, "fetch_misal");
        do_req(1'b1, 1'b1, 2'd2, 32'h204, 32'hCAFEBABE, "store_word");
        do_req(1'b1, 1'b0, 2'd1, 32'h206, 32'd0, "load_half_hi");
        do_req(1'b1, 1'b1, 2'd0, 32'h207, 32'h5A, "store_byte_3");
        do_req(1'b1, 1'b0, 2'd2, 32'h204, 32'd0, "load_after_merge");
    endtask

    task automatic test_round_robin();
        bit fetch_turn;
        logic [31:0] exp;
        do_reset();
        fetch_turn = 1'b1;
        @(negedge CLK);
        in_fetch_req_valid = 1'b1; in_fetch_addr = 32'h100;
        in_data_req_valid = 1'b1; in_data_req_write = 1'b0; in_data_req_size = 2'd2;
        in_data_req_addr = 32'h104; in_data_req_wdata = 32'd0;
        #1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_fetch_req_ready !== fetch_turn || out_data_req_ready !== !fetch_turn) begin
                errors++; $display("FAIL rr_grant%0d: got f=%b d=%b, required f=%b d=%b", i,
                                   out_fetch_req_ready, out_data_req_ready, fetch_turn, !fetch_turn);
            end
            @(posedge CLK); @(posedge CLK); #1;
            exp = fetch_turn ? ref_mem[8'h40] : ref_mem[8'h41];
            checks++;
            if (out_fetch_resp_valid !== fetch_turn || out_data_resp_valid !== !fetch_turn) begin
                errors++; $display("FAIL rr_resp%0d: got f=%b d=%b, required f=%b d=%b", i,
                                   out_fetch_resp_valid, out_data_resp_valid, fetch_turn, !fetch_turn);
            end
            checks++;
            if ((fetch_turn ? out_fetch_resp_data : out_data_resp_data) !== exp) begin
                errors++; $display("FAIL rr_data%0d: got %h, required %h", i,
                                   fetch_turn ? out_fetch_resp_data : out_data_resp_data, exp);
            end
            fetch_turn = !fetch_turn;
            @(negedge CLK); #1;
        end
        in_fetch_req_valid = 1'b0; in_data_req_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset_abort();
        @(negedge CLK);
        in_data_req_valid = 1'b1; in_data_req_write = 1'b1; in_data_req_size = 2'd0;
        in_data_req_addr = 32'h41; in_data_req_wdata = 32'hEE;
        #1;
        checks++;
        if (out_data_req_ready !== 1'b1) begin
            errors++; $display("FAIL abort_grant: got %b, required 1", out_data_req_ready);
        end
        @(posedge CLK); #1;
        in_data_req_valid = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if (out_mem_write_enable !== 1'b1) begin
            errors++; $display("FAIL abort_write_cycle: got we=%b, required 1", out_mem_write_enable);
        end
        RESET = 1'b1; #1;
        checks++;
        if (out_mem_write_enable !== 1'b0) begin
            errors++; $display("FAIL abort_we_forced: got %b, required 0", out_mem_write_enable);
        end
        @(posedge CLK); #1;
        RESET = 1'b0; #1;
        checks++;
        if (out_data_resp_valid !== 1'b0 || out_fetch_req_ready !== 1'b1 || out_data_req_ready !== 1'b1) begin
            errors++; $display("FAIL abort_after: got resp=%b rdy=%b%b, required resp=0 rdy=11",
                               out_data_resp_valid, out_fetch_req_ready, out_data_req_ready);
        end
        @(posedge CLK); #1;
        checks++;
        if (out_data_resp_valid !== 1'b0) begin
            errors++; $display("FAIL abort_no_resp: got %b, required 0", out_data_resp_valid);
        end
        checks++;
        if (mem[8'h10] !== ref_mem[8'h10]) begin
            errors++; $display("FAIL abort_mem: got %h, required %h", mem[8'h10], ref_mem[8'h10]);
        end
    endtask

    task automatic test_random();
        bit is_data, wr;
        logic [1:0] sz;
        logic [31:0] addr, wd;
        for (int i = 0; i < 40; i++) begin
            is_data = 1'($urandom_range(0, 1));
            wr      = 1'($urandom_range(0, 1));
            sz      = 2'($urandom_range(0, 3));
            addr    = 32'($urandom_range(0, 1023));
            wd      = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                if (sz == 2'd2 || !is_data) addr[1:0] = 2'b00;
                else if (sz == 2'd1) addr[0] = 1'b0;
            end
            do_req(is_data, wr, sz, addr, wd, "rand");
        end
    endtask

    task automatic test_mem_final();
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL mem_final: got %0d differing words, required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_round_robin();
        test_reset_abort();
        test_random();
        test_mem_final();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 RESET  in  1  synchronous, active-high reset.
REQ-003 in_fetch_req_valid / out_fetch_req_ready  in/out  1/1  fetch request handshake.
REQ-004 in_fetch_addr  in  32  fetch byte address.
REQ-005 out_fetch_resp_valid / out_fetch_resp_data / out_fetch_resp_exception  out  1/32/1  fetch response; one-cycle pulse, no backpressure.
REQ-006 in_data_req_valid / out_data_req_ready  in/out  1/1  load/store request handshake.
REQ-007 in_data_req_write  in  1  1 = store, 0 = load.
REQ-008 in_data_req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-009 in_data_req_addr / in_data_req_wdata  in  32/32  byte address; store data, right-justified.
REQ-010 out_data_resp_valid / out_data_resp_data / out_data_resp_exception  out  1/32/1  data response; one-cycle pulse, no backpressure.
REQ-011 out_mem_read_address / in_mem_read_data  out/in  32/32  word memory read port; data combinational, same cycle.
REQ-012 out_mem_write_enable / out_mem_write_address / out_mem_write_data  out  1/32/32  word memory write port; written on rising edge.

Function
REQ-013 The FSM SHALL have states IDLE, ACCESS and WRITE; both req_ready outputs SHALL be high only in IDLE.
REQ-014 Arbitration in IDLE SHALL use round-robin. A lone valid requester wins. When both are valid, the requester not granted last time wins. Exactly one handshake occurs per cycle.
REQ-015 On grant at edge N, the FSM SHALL register source, address, size, write and wdata, then enter ACCESS for cycle N+1.
REQ-016 In ACCESS, out_mem_read_address SHALL equal {addr[31:2],2'b00}. In all other states it SHALL be 0.
REQ-017 Misaligned requests SHALL be flagged. A misaligned request is: half with addr[0]=1, word with addr[1:0]!=0, or size=3. Fetch is always word size.
REQ-018 Fetch, load, word store and misaligned requests SHALL leave ACCESS to IDLE. The response pulse SHALL be registered and high in cycle N+2.
REQ-019 For an aligned word store, out_mem_write_enable SHALL be high in ACCESS with write data = wdata.
REQ-020 An aligned byte or half store SHALL latch in_mem_read_data in ACCESS and go to WRITE in cycle N+2.
REQ-021 In WRITE, the merged word SHALL be written. Only lanes addr[1:0] .. addr[1:0]+size_bytes-1 take wdata; all other lanes keep the latched word. The FSM then returns to IDLE and the response pulses in cycle N+3.
REQ-022 out_mem_write_address SHALL be the aligned word address whenever write_enable is high.
REQ-023 Load response data SHALL be the read word shifted right by 8*addr[1:0], zero-extended above the access size. Fetch data SHALL be the unshifted word.
REQ-024 A misaligned request SHALL perform no memory write. Its response carries exception=1 and data=0.
REQ-025 Aligned responses SHALL carry exception=0. Store responses SHALL carry data=0.
REQ-026 Only the response of the granted source SHALL pulse. Each response pulse SHALL last exactly one cycle.
REQ-027 A new request MAY be accepted in the same cycle that the previous response pulses.
REQ-028 out_mem_write_enable SHALL be forced low in any cycle where RESET=1.

Reset
REQ-029 While RESET=1 at an edge, the FSM SHALL reset to IDLE and the round-robin pointer SHALL favour fetch.
REQ-030 After that reset edge, all resp_valid, resp_data and resp_exception outputs SHALL be 0 and latched request state SHALL be cleared.
REQ-031 RESET in ACCESS or WRITE SHALL abort the operation. No write occurs and no response is issued.
REQ-032 Both req_ready outputs SHALL be 1 in the first cycle after RESET deasserts.

Verification
REQ-033 Fetch 0x100 with mem[0x100]=0x00C0FFEE -> fetch_resp_valid at N+2, data 0x00C0FFEE, exception 0.
REQ-034 Load byte 0x103 with word 0xAABBCCDD -> data_resp data 0x000000AA at N+2.
REQ-035 Store half 0x202, wdata 0x1234, old word 0x55667788 -> mem read at N+1; write 0x12347788 at N+2 (WRITE); response at N+3; data 0.
REQ-036 Fetch and data valid together, repeated -> grants alternate fetch, data, fetch, data starting with fetch after reset; no double grant.
REQ-037 Load word 0x301 and size=3 request -> exception=1 at N+2, write_enable never high, data 0.
REQ-038 RESET asserted in the WRITE cycle of a byte store -> write_enable low, no data_resp_valid, FSM in IDLE with ready=1 after release.
